// File: rtl/dataflow_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dataflow_pkg                                                               |
// | Shared types and helpers for the FIFO read-side stream datapath.           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package dataflow_pkg;

   localparam int unsigned MIN_READ_LATENCY = 1;
   localparam int unsigned MAX_READ_LATENCY = 4;

   typedef enum logic [1:0] {
      Q_IDLE = 2'd0,
      Q_PUSH = 2'd1,
      Q_POP  = 2'd2,
      Q_BOTH = 2'd3
   } q_op_e;

   // A registered FIFO memory output adds one cycle to the read path.
   function automatic int unsigned memory_read_latency(input logic out_reg);
      return out_reg ? 2 : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/stream_skid_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stream_skid_queue                                                          |
// | Circular output queue with level counter; head word drives the stream.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module stream_skid_queue
   import dataflow_pkg::*;
#(
   parameter  int WIDTH  = 16,
   parameter  int QDEPTH = 3,
   localparam int LW     = $clog2(QDEPTH + 1),
   localparam int PW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   output logic [LW-1:0]    o_level
);

   logic [WIDTH-1:0] r_mem [QDEPTH];
   logic [PW-1:0]    r_head;
   logic [PW-1:0]    r_tail;
   logic [LW-1:0]    r_level;

   logic             w_push;
   logic             w_pop;
   logic [PW-1:0]    w_head_nxt;
   logic [PW-1:0]    w_tail_nxt;
   q_op_e            w_op;

   assign w_push     = i_push;
   assign w_pop      = i_pop & (r_level != '0);
   assign w_head_nxt = (r_head == PW'(QDEPTH - 1)) ? '0 : r_head + 1'b1;
   assign w_tail_nxt = (r_tail == PW'(QDEPTH - 1)) ? '0 : r_tail + 1'b1;

   always_comb begin
      w_op = Q_IDLE;
      if (w_push && w_pop) begin
         w_op = Q_BOTH;
      end else if (w_push) begin
         w_op = Q_PUSH;
      end else if (w_pop) begin
         w_op = Q_POP;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < QDEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_head  <= '0;
         r_tail  <= '0;
         r_level <= '0;
      end else if (i_flush) begin
         // Flush beats a same-cycle push; the word being handed out still counts as delivered.
         r_head  <= '0;
         r_tail  <= '0;
         r_level <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_tail] <= i_push_data;
            r_tail        <= w_tail_nxt;
         end
         if (w_pop) begin
            r_head <= w_head_nxt;
         end
         case (w_op)
            Q_PUSH:  r_level <= r_level + 1'b1;
            Q_POP:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   assign o_valid = (r_level != '0);
   assign o_data  = r_mem[r_head];
   assign o_level = r_level;

   a_no_push_when_full: assert property (
      @(posedge clk) disable iff (!rst_n)
      !(i_push && !i_flush && (r_level == LW'(QDEPTH)))
   );

endmodule
`default_nettype wire

// File: rtl/fifo_stream_adapter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_stream_adapter                                                        |
// | Issues FIFO pops with credit, absorbs read latency, drives valid/ready.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fifo_stream_adapter
   import dataflow_pkg::*;
#(
   parameter  int WIDTH        = 16,
   parameter  int READ_LATENCY = 2,
   localparam int QDEPTH       = READ_LATENCY + 1,
   localparam int LW           = $clog2(QDEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_data,
   output logic             fifo_rd_en,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [LW-1:0]    level
);

   localparam int CW = LW + 1;

   if ((READ_LATENCY < MIN_READ_LATENCY) || (READ_LATENCY > MAX_READ_LATENCY)) begin : g_bad_latency
      $error("fifo_stream_adapter: READ_LATENCY out of range");
   end

   logic [READ_LATENCY-1:0] r_infl;
   logic [CW-1:0]           w_infl_cnt;
   logic [CW-1:0]           w_commit;
   logic                    w_xfer;
   logic                    w_credit;
   logic                    w_rd_en;

   always_comb begin
      w_infl_cnt = '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
         w_infl_cnt = w_infl_cnt + CW'(r_infl[i]);
      end
   end

   // Words already owned by the queue or on their way, less the one leaving this cycle.
   assign w_xfer     = out_valid & out_ready;
   assign w_commit   = CW'(level) + w_infl_cnt - CW'(w_xfer);
   assign w_credit   = (w_commit < CW'(QDEPTH));
   assign w_rd_en    = rst_n & ~flush & ~fifo_empty & w_credit;
   assign fifo_rd_en = w_rd_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_infl <= '0;
      end else if (flush) begin
         r_infl <= '0;
      end else begin
         r_infl <= (r_infl << 1) | READ_LATENCY'(w_rd_en);
      end
   end

   stream_skid_queue #(
      .WIDTH  (WIDTH),
      .QDEPTH (QDEPTH)
   ) u_queue (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_flush     (flush),
      .i_push      (r_infl[READ_LATENCY-1]),
      .i_push_data (fifo_data),
      .i_pop       (w_xfer),
      .o_valid     (out_valid),
      .o_data      (out_data),
      .o_level     (level)
   );

endmodule
`default_nettype wire
